// File: rtl/risc_debug_pkg.sv
// Shared types and constants for the RISC-V VGA debug display and its stimulus generator.
package risc_debug_pkg;

    typedef enum logic [2:0] {
        MODE_ADD,
        MODE_ROTL,
        MODE_XOR,
        MODE_LFSR,
        MODE_HOLD
    } ch_mode_e;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PAUSED,
        ST_STEP
    } dbg_state_e;

    localparam logic [31:0] DEFAULT_PC    = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_INSTR = 32'h0000_0013;  // addi x0,x0,0 (nop)

endpackage

// File: rtl/risc_debug_sw_sync.sv
// Two-flop synchroniser for a board switch, followed by a rising-edge detector.
module risc_debug_sw_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sw,
    output logic o_level,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_sw;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;

endmodule

// File: rtl/risc_debug_stimgen.sv
// Stimulus generator standing in for a core: NUM_CH evolving channels plus cycle and
// update counters, with run / pause / single-step / reload control from board switches.
//
//   state     | meaning
//   ST_RUN    | channels update on every run tick
//   ST_PAUSED | no tick updates; waiting for a step edge or un-pause
//   ST_STEP   | one update this cycle, then back to ST_PAUSED
module risc_debug_stimgen
    import risc_debug_pkg::*;
#(
    parameter int                             NUM_CH      = 6,
    parameter int                             WIDTH       = 32,
    parameter int                             PERIOD_LOG2 = 20,
    parameter logic [NUM_CH-1:0][WIDTH-1:0]   CH_INIT     = {NUM_CH{WIDTH'(0)}},
    parameter logic [NUM_CH-1:0][WIDTH-1:0]   CH_STEP     = {NUM_CH{WIDTH'(1)}},
    parameter logic [NUM_CH-1:0][2:0]         CH_MODE     = {NUM_CH{MODE_ADD}}
) (
    input  logic                           i_clock,
    input  logic                           i_sw0,
    input  logic                           i_sw1,
    input  logic                           i_sw2,
    input  logic                           i_sw3,
    output logic [NUM_CH-1:0][WIDTH-1:0]   o_ch_data,
    output logic [WIDTH-1:0]               o_clock_counter,
    output logic [WIDTH-1:0]               o_step_count,
    output logic                           o_update_strobe,
    output logic                           o_paused
);

    logic             w_sw1_level;
    logic             w_sw1_rise;
    logic             w_sw2_rise;
    logic             w_sw3_rise;
    logic             w_tick;
    logic             w_update_req;
    logic             w_update;

    dbg_state_e       r_state;
    logic             r_paused;
    logic             r_step_kill;
    logic [WIDTH-1:0] r_clock_counter;
    logic [WIDTH-1:0] r_step_count;
    logic             r_update_strobe;

    risc_debug_sw_sync u_sync_sw1 (
        .i_clk   (i_clock),
        .i_rst   (i_sw0),
        .i_sw    (i_sw1),
        .o_level (w_sw1_level),
        .o_rise  (w_sw1_rise)
    );

    risc_debug_sw_sync u_sync_sw2 (
        .i_clk   (i_clock),
        .i_rst   (i_sw0),
        .i_sw    (i_sw2),
        .o_level (),
        .o_rise  (w_sw2_rise)
    );

    risc_debug_sw_sync u_sync_sw3 (
        .i_clk   (i_clock),
        .i_rst   (i_sw0),
        .i_sw    (i_sw3),
        .o_level (),
        .o_rise  (w_sw3_rise)
    );

    assign w_tick       = &r_clock_counter[PERIOD_LOG2-1:0];
    assign w_update_req = ((r_state == ST_RUN) && w_tick) || (r_state == ST_STEP);
    // A reload seen together with the step request still cancels that step one cycle later.
    assign w_update     = w_update_req && !w_sw3_rise && !r_step_kill;

    always_ff @(posedge i_clock or posedge i_sw0) begin
        if (i_sw0) begin
            r_state         <= ST_RUN;
            r_paused        <= 1'b0;
            r_step_kill     <= 1'b0;
            r_clock_counter <= '0;
            r_step_count    <= '0;
            r_update_strobe <= 1'b0;
        end else begin
            r_clock_counter <= r_clock_counter + WIDTH'(1);
            r_update_strobe <= w_update;
            if (w_update) begin
                r_step_count <= r_step_count + WIDTH'(1);
            end
            case (r_state)
                ST_RUN: begin
                    if (w_sw1_level) begin
                        r_state  <= ST_PAUSED;
                        r_paused <= 1'b1;
                    end
                end
                ST_PAUSED: begin
                    if (!w_sw1_level) begin
                        r_state  <= ST_RUN;
                        r_paused <= 1'b0;
                    end else if (w_sw2_rise) begin
                        r_state     <= ST_STEP;
                        r_step_kill <= w_sw3_rise;
                    end
                end
                ST_STEP: begin
                    r_state     <= ST_PAUSED;
                    r_step_kill <= 1'b0;
                end
                default: begin
                    r_state     <= ST_RUN;
                    r_paused    <= 1'b0;
                    r_step_kill <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [WIDTH-1:0] r_val;
        logic [WIDTH-1:0] w_next;

        always_comb begin
            w_next = r_val;
            case (CH_MODE[g])
                MODE_ADD:  w_next = r_val + CH_STEP[g];
                MODE_ROTL: w_next = {r_val[WIDTH-2:0], r_val[WIDTH-1]};
                MODE_XOR:  w_next = r_val ^ CH_STEP[g];
                MODE_LFSR: begin
                    // The all-zero state would lock up a Galois LFSR forever.
                    if (r_val == '0) begin
                        w_next = WIDTH'(1);
                    end else if (r_val[0]) begin
                        w_next = (r_val >> 1) ^ CH_STEP[g];
                    end else begin
                        w_next = r_val >> 1;
                    end
                end
                default:   w_next = r_val;
            endcase
        end

        always_ff @(posedge i_clock or posedge i_sw0) begin
            if (i_sw0) begin
                r_val <= CH_INIT[g];
            end else if (w_sw3_rise) begin
                r_val <= CH_INIT[g];
            end else if (w_update) begin
                r_val <= w_next;
            end
        end

        assign o_ch_data[g] = r_val;
    end

    assign o_clock_counter = r_clock_counter;
    assign o_step_count    = r_step_count;
    assign o_update_strobe = r_update_strobe;
    assign o_paused        = r_paused;

endmodule

// File: tb/tb_risc_debug_stimgen.sv
// Directed bench for risc_debug_stimgen: phase table plus hand sequences for reset and wrap.
module tb_risc_debug_stimgen;
    import risc_debug_pkg::*;

    localparam logic [3:0][31:0] P_INIT = {32'h0000_0001, 32'h1122_3344, 32'h8000_0001, 32'h0000_1000};
    localparam logic [3:0][31:0] P_STEP = {32'hA300_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0004};
    localparam logic [3:0][2:0]  P_MODE = {MODE_LFSR, MODE_XOR, MODE_ROTL, MODE_ADD};

    localparam logic [1:0][31:0] A_INIT = {32'h0000_CAFE, 32'h0000_0000};
    localparam logic [1:0][31:0] A_STEP = {32'h0000_0000, 32'hA300_0000};
    localparam logic [1:0][2:0]  A_MODE = {MODE_HOLD, MODE_LFSR};

    logic              i_clock;
    logic              i_sw0, i_sw1, i_sw2, i_sw3;
    logic [3:0][31:0]  o_ch_data;
    logic [31:0]       o_clock_counter, o_step_count;
    logic              o_update_strobe, o_paused;

    logic [1:0][31:0]  a_ch_data;
    logic [31:0]       a_clock_counter, a_step_count;
    logic              a_update_strobe, a_paused;

    risc_debug_stimgen #(
        .NUM_CH(4), .WIDTH(32), .PERIOD_LOG2(4),
        .CH_INIT(P_INIT), .CH_STEP(P_STEP), .CH_MODE(P_MODE)
    ) dut (
        .i_clock(i_clock), .i_sw0(i_sw0), .i_sw1(i_sw1), .i_sw2(i_sw2), .i_sw3(i_sw3),
        .o_ch_data(o_ch_data), .o_clock_counter(o_clock_counter), .o_step_count(o_step_count),
        .o_update_strobe(o_update_strobe), .o_paused(o_paused)
    );

    risc_debug_stimgen #(
        .NUM_CH(2), .WIDTH(32), .PERIOD_LOG2(4),
        .CH_INIT(A_INIT), .CH_STEP(A_STEP), .CH_MODE(A_MODE)
    ) dut_aux (
        .i_clock(i_clock), .i_sw0(i_sw0), .i_sw1(i_sw1), .i_sw2(i_sw2), .i_sw3(i_sw3),
        .o_ch_data(a_ch_data), .o_clock_counter(a_clock_counter), .o_step_count(a_step_count),
        .o_update_strobe(a_update_strobe), .o_paused(a_paused)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    typedef struct {
        logic        sw1, sw2, sw3;
        int          cycles;
        int          exp_strobes;
        int          exp_edge;
        logic [31:0] exp_step;
        logic [31:0] exp_ch0;
        logic        exp_paused;
        logic        exp_init;
    } phase_t;

    phase_t ph[11];
    int n_total = 0;
    int n_pass  = 0;
    int n_strb;
    int last_edge;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic run_edges(input int n);
        n_strb    = 0;
        last_edge = 0;
        for (int e = 1; e <= n; e++) begin
            @(posedge i_clock);
            #1;
            if (o_update_strobe) begin
                n_strb++;
                last_edge = e;
            end
        end
    endtask

    initial begin
        //                 sw1   sw2   sw3  cyc str edg step           ch0            pau   init
        ph[0]  = '{1'b1, 1'b0, 1'b0, 100, 0,  0, 32'd1, 32'h0000_1004, 1'b1, 1'b0};  // pause
        ph[1]  = '{1'b1, 1'b1, 1'b0,   4, 1,  4, 32'd2, 32'h0000_1008, 1'b1, 1'b0};  // step
        ph[2]  = '{1'b1, 1'b0, 1'b0,  10, 0,  0, 32'd2, 32'h0000_1008, 1'b1, 1'b0};
        ph[3]  = '{1'b1, 1'b1, 1'b1,   6, 0,  0, 32'd2, 32'h0000_1000, 1'b1, 1'b1};  // step+reload
        ph[4]  = '{1'b1, 1'b0, 1'b0,   5, 0,  0, 32'd2, 32'h0000_1000, 1'b1, 1'b0};
        ph[5]  = '{1'b1, 1'b1, 1'b0,   4, 1,  4, 32'd3, 32'h0000_1004, 1'b1, 1'b0};  // step again
        ph[6]  = '{1'b1, 1'b0, 1'b1,   4, 0,  0, 32'd3, 32'h0000_1000, 1'b1, 1'b1};  // reload only
        ph[7]  = '{1'b0, 1'b0, 1'b0,  20, 1, 11, 32'd4, 32'h0000_1004, 1'b0, 1'b0};  // resume
        ph[8]  = '{1'b0, 1'b1, 1'b0,  16, 1,  7, 32'd5, 32'h0000_1008, 1'b0, 1'b0};  // sw2 in run
        ph[9]  = '{1'b0, 1'b0, 1'b0,   4, 0,  0, 32'd5, 32'h0000_1008, 1'b0, 1'b0};
        ph[10] = '{1'b1, 1'b0, 1'b0,  10, 1,  3, 32'd6, 32'h0000_100C, 1'b1, 1'b0};  // tick on pause edge

        i_sw0 = 1'b1; i_sw1 = 1'b0; i_sw2 = 1'b0; i_sw3 = 1'b0;
        repeat (3) @(posedge i_clock);
        #1;
        check("rst_counter", 128'(o_clock_counter), 128'd0);
        check("rst_step",    128'(o_step_count),    128'd0);
        check("rst_ch_data", 128'(o_ch_data),       128'(P_INIT));
        check("rst_strobe",  128'(o_update_strobe), 128'd0);
        check("rst_paused",  128'(o_paused),        128'd0);
        i_sw0 = 1'b0;

        run_edges(16);
        check("tick1_strobes", 128'(n_strb),          128'd1);
        check("tick1_edge",    128'(last_edge),       128'd16);
        check("tick1_counter", 128'(o_clock_counter), 128'd16);
        check("tick1_step",    128'(o_step_count),    128'd1);
        check("tick1_ch_data", 128'(o_ch_data),
              128'({32'hA300_0000, 32'hEEDD_CCBB, 32'h0000_0003, 32'h0000_1004}));
        check("lfsr_zero_escape", 128'(a_ch_data), 128'({32'h0000_CAFE, 32'h0000_0001}));

        for (int i = 0; i < 11; i++) begin
            i_sw1 = ph[i].sw1; i_sw2 = ph[i].sw2; i_sw3 = ph[i].sw3;
            run_edges(ph[i].cycles);
            check($sformatf("ph%0d_strobes", i), 128'(n_strb),       128'(ph[i].exp_strobes));
            check($sformatf("ph%0d_edge", i),    128'(last_edge),    128'(ph[i].exp_edge));
            check($sformatf("ph%0d_step", i),    128'(o_step_count), 128'(ph[i].exp_step));
            check($sformatf("ph%0d_ch0", i),     128'(o_ch_data[0]), 128'(ph[i].exp_ch0));
            check($sformatf("ph%0d_paused", i),  128'(o_paused),     128'(ph[i].exp_paused));
            if (ph[i].exp_init)
                check($sformatf("ph%0d_reload", i), 128'(o_ch_data), 128'(P_INIT));
        end

        @(posedge i_clock);
        #3;
        i_sw0 = 1'b1;
        #1;
        check("async_rst_counter", 128'(o_clock_counter), 128'd0);
        check("async_rst_step",    128'(o_step_count),    128'd0);
        check("async_rst_ch_data", 128'(o_ch_data),       128'(P_INIT));
        check("async_rst_paused",  128'(o_paused),        128'd0);
        i_sw1 = 1'b0;
        repeat (2) @(posedge i_clock);
        #1;
        i_sw0 = 1'b0;
        run_edges(3);
        check("post_rst_counter", 128'(o_clock_counter), 128'd3);

        force dut.r_clock_counter = 32'hFFFF_FFFE;
        #1;
        release dut.r_clock_counter;
        run_edges(1);
        check("wrap_ffff_counter", 128'(o_clock_counter), 128'hFFFF_FFFF);
        check("wrap_ffff_strobe",  128'(n_strb),          128'd0);
        run_edges(1);
        check("wrap_zero_counter", 128'(o_clock_counter), 128'd0);
        check("wrap_tick_strobe",  128'(n_strb),          128'd1);
        check("wrap_tick_step",    128'(o_step_count),    128'd1);
        check("wrap_tick_ch0",     128'(o_ch_data[0]),    128'h1004);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
